// File: rtl/clk_tick_sched.sv
// Clock-enable scheduler: emits one-cycle tick_o strobes every div_q cycles in RUN,
// a counted burst of ticks in STEP, and nothing in IDLE.
module clk_tick_sched #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned STEP_W      = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic              cfg_ready_o,
    input  logic              run_i,
    input  logic              step_valid_i,
    input  logic [STEP_W-1:0] step_cnt_i,
    output logic              step_ready_o,
    input  logic              halt_i,
    output logic              tick_o,
    output logic              step_done_o,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    localparam logic [DIV_W-1:0]  DIV_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_RESET   = DIV_W'(DEFAULT_DIV);
    localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;

    logic                cfg_ready;
    logic                step_ready;
    logic                cfg_fire;
    logic                step_fire;
    logic                terminal;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // ready depends only on state and the mode inputs, never on valid.
    always_comb begin
        cfg_ready  = (state_q == ST_IDLE) && !halt_i;
        step_ready = (state_q == ST_IDLE) && !run_i && !halt_i;
        cfg_fire   = cfg_valid_i && cfg_ready;
        step_fire  = step_valid_i && step_ready;
        terminal   = (cnt_q == (div_q - DIV_ONE));
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    div_d = (cfg_div_i == '0) ? DIV_ONE : cfg_div_i;
                end
                if (!halt_i) begin
                    if (run_i) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (step_fire) begin
                        if (step_cnt_i != '0) begin
                            state_d = ST_STEP;
                            cnt_d   = '0;
                            rem_d   = step_cnt_i;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end

            ST_RUN: begin
                // Leaving RUN suppresses the tick even when the count is terminal.
                if (halt_i || !run_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (terminal) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end

            ST_STEP: begin
                if (halt_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (terminal) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    rem_d  = rem_q - STEP_ONE;
                    if (rem_q == STEP_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_RESET;
            cnt_q   <= '0;
            rem_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign cfg_ready_o  = cfg_ready;
    assign step_ready_o = step_ready;
    assign tick_o       = tick_q;
    assign step_done_o  = done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign state_o      = state_q;

endmodule

// File: doc/clk_tick_sched.md
Name: clk_tick_sched

Overview:
- Programmable clock-enable scheduler for the pipelined core and its peripherals.
- Generates single-cycle `tick_o` strobes at a runtime-configurable divide ratio, replacing free-running derived clocks with enables on the single system clock.
- Supports three modes: continuous RUN, N-tick STEP (debug single/multi-step) and HALT.
- Divide ratio is reconfigurable through a valid/ready handshake, and only while idle, so the period never glitches mid-operation.

Parameters:
- DIV_W, 16, width of divide-ratio register and counter.
- STEP_W, 8, width of step-count request.
- DEFAULT_DIV, 4, divide ratio loaded at reset (must be ≥1 and < 2**DIV_W).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_valid_i  in  1  divide-ratio write request.
- cfg_div_i  in  DIV_W  requested ratio (ticks per cfg_div_i cycles).
- cfg_ready_o  out  1  config accepted this cycle when high with cfg_valid_i.
- run_i  in  1  level: continuous tick generation while high.
- step_valid_i  in  1  step request.
- step_cnt_i  in  STEP_W  number of ticks to issue.
- step_ready_o  out  1  step request accepted when high with step_valid_i.
- halt_i  in  1  abort: forces IDLE from any state.
- tick_o  out  1  registered one-cycle clock-enable strobe.
- step_done_o  out  1  one-cycle pulse on completion of a step request.
- busy_o  out  1  state != IDLE.
- state_o  out  2  IDLE=00, RUN=01, STEP=10.

Behaviour:
- Single clock domain; all state changes on posedge clk_i. Reset is synchronous and active-high (sampled on the edge).
- Reset values:
  - state = IDLE; div_q = DEFAULT_DIV; cnt = 0; remaining = 0.
  - tick_o = 0; step_done_o = 0; busy_o = 0; state_o = 00.
  - Reset overrides every other input in the same cycle.
- Ready signals:
  - cfg_ready_o = (state==IDLE) && !halt_i.
  - step_ready_o = (state==IDLE) && !run_i && !halt_i.
- Config:
  - Accepted config updates div_q at the next edge.
  - cfg_div_i==0 is stored as 1.
  - When both are accepted in the same cycle, config and mode entry apply together; the new div_q governs the new mode.
- IDLE transitions, in priority order:
  - halt_i: stay IDLE.
  - run_i: go to RUN.
  - step_valid_i with step_cnt_i!=0: go to STEP, remaining <= step_cnt_i.
  - step_valid_i with step_cnt_i==0: accepted; step_done_o pulses next cycle; stay IDLE.
  - On any mode entry, cnt <= 0.
- Counting in RUN/STEP:
  - When cnt==div_q-1: cnt <= 0 and tick_o <= 1 (registered, visible next cycle).
  - Otherwise: cnt <= cnt+1 and tick_o <= 0.
  - If run_i is sampled high in IDLE at cycle T, the first tick_o is high at T+1+div_q, then every div_q cycles.
  - div_q==1 gives continuous tick_o.
- RUN exit: run_i low or halt_i moves to IDLE next edge and clears cnt. No tick is generated in that cycle, even at terminal count.
- STEP:
  - Each generated tick decrements remaining.
  - The tick generated with remaining==1 moves to IDLE.
  - step_done_o is asserted coincident with that final tick_o.
  - run_i is ignored during STEP.
- halt_i in RUN/STEP:
  - IDLE next edge; cnt and remaining cleared.
  - No tick generated that cycle; no step_done_o.
- tick_o is never high for two consecutive cycles unless div_q==1.
- tick_o never appears in the cycle after IDLE is entered, except the final STEP tick registered on the exit edge.
- Counter arithmetic is DIV_W bits. cnt never exceeds div_q-1, so there is no wrap beyond the terminal value.

Test Plan:
- Reset, run_i high at cycle 0 with DEFAULT_DIV=4 -> tick_o high at cycles 5, 9, 13; busy_o=1 from cycle 1; state_o=01.
- In IDLE, cfg_valid_i=1, cfg_div_i=0, then run_i=1 -> div_q=1; tick_o high every cycle starting 2 cycles after run_i sampled.
- cfg div=2, step_cnt_i=3 -> exactly 3 ticks spaced 2 cycles apart; step_done_o with the 3rd tick; state_o=00 next cycle; no further ticks.
- STEP cnt=5, assert halt_i after first tick -> no more tick_o, step_done_o never pulses, busy_o=0 next cycle.
- cfg_valid_i during RUN -> cfg_ready_o=0, div_q unchanged. run_i and step_valid_i together in IDLE -> RUN entered, step_ready_o=0, step not consumed.
- rst_i asserted mid-RUN after cfg div=7 -> next cycle all outputs 0, state IDLE. Subsequent run gives period 4 (DEFAULT_DIV restored).
